if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: holds the program counter, selects the next PC (sequential, branch, jump, jump-register), drives the instruction-memory address and captures the fetched word into the IF/ID pipeline register. It sits directly upstream of the ID stage. It consumes the stall controls produced by the load-use hazard unit (PCWrite, IF_ID_Write) and the branch flush raised in ID.

## Interface
- PC_WIDTH, 32, width of PC and all address/target buses
- INSTR_WIDTH, 32, instruction word width
- RESET_PC, 0, PC value loaded on reset (must be word-aligned)

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- PCWrite  in  1  1 = PC may update; 0 = hold PC (load-use stall)
- IF_ID_Write  in  1  1 = IF/ID register may load; 0 = hold
- IF_Flush  in  1  1 = squash instruction being captured into IF/ID
- PCSrc  in  2  00 PC+4, 01 branch_target, 10 jump_target, 11 jr_target
- branch_target  in  PC_WIDTH  taken-branch address from ID
- jump_target  in  PC_WIDTH  fully formed j/jal address from ID
- jr_target  in  PC_WIDTH  register value for jr from ID
- imem_addr  out  PC_WIDTH  instruction-memory address (= pc)
- imem_data  in  INSTR_WIDTH  instruction word, combinational read of imem_addr
- pc  out  PC_WIDTH  current PC register
- IF_ID_PC4  out  PC_WIDTH  registered PC+4 of captured instruction
- IF_ID_Instr  out  INSTR_WIDTH  registered instruction
- IF_ID_Valid  out  1  1 = IF_ID_Instr is a real fetched instruction

## Operation
- pc_plus4 = pc + 4, modulo 2^PC_WIDTH (0xFFFFFFFC + 4 = 0x00000000, no flag).
- next_pc mux selects by PCSrc. Bits [1:0] of the selected value are forced to 00 before loading the PC, so pc is always word-aligned.
- PC register: loads next_pc when PCWrite=1. Holds when PCWrite=0, regardless of PCSrc, so a redirect presented during a stall is ignored.
- imem_addr = pc, driven combinationally.
- IF/ID register is updated on each edge with the following priority:
  1. IF_Flush=1: IF_ID_Instr←0 (sll $0 nop), IF_ID_PC4←pc_plus4, IF_ID_Valid←0. The flush wins over IF_ID_Write=0.
  2. else IF_ID_Write=1: IF_ID_Instr←imem_data, IF_ID_PC4←pc_plus4, IF_ID_Valid←1.
  3. else: hold all three.
- PCWrite and IF_ID_Write act independently. The normal stall drives both to 0. Any other combination is still honoured exactly as listed above.
- No internal state beyond the PC and the IF/ID register (PC, PC4, Instr, Valid).

## Timing
- Reset (asynchronous, takes effect immediately, no clock needed): pc=RESET_PC, IF_ID_PC4=0, IF_ID_Instr=0, IF_ID_Valid=0.
- First rising edge after rst deasserts:
  - IF/ID captures imem_data at RESET_PC with IF_ID_PC4=RESET_PC+4 and Valid=1.
  - pc becomes next_pc.
- Fetch latency: the instruction at address A appears on IF_ID_Instr one edge after pc=A.
- Redirect: PCSrc/target sampled at the edge.
  - pc = target after that edge.
  - The same edge captures the wrong-path instruction unless IF_Flush=1 in that cycle. ID asserts PCSrc≠00 and IF_Flush together for taken branches and jumps.
- Stall: each cycle with PCWrite=0 and IF_ID_Write=0 freezes pc and the IF/ID register for exactly that cycle. Fetch resumes on the first edge with the controls high.
- rst asserted mid-stall or mid-redirect: reset wins immediately and all pending controls are discarded.

## Test plan
- Reset/sequential: RESET_PC=0, imem returns word = address | 0xA0000000, PCSrc=00, controls high, 4 edges.
  - Required: IF_ID_Instr sequence A0000000, A0000004, A0000008, A000000C.
  - Required: IF_ID_PC4 = 4, 8, 0xC, 0x10; Valid=1 from the first edge.
- Load-use stall: at pc=0x8, drive PCWrite=IF_ID_Write=0 for 1 cycle.
  - Required: pc stays 0x8 and IF_ID holds the instruction from 0x4 for one extra cycle.
  - Required: the next edge captures the instruction at 0x8.
- Taken branch with flush: pc=0x10, PCSrc=01, branch_target=0x40, IF_Flush=1 for one cycle.
  - Required: pc=0x40, IF_ID_Instr=0, Valid=0.
  - Required: the following edge captures the instruction at 0x40 with Valid=1.
- Redirect during stall: PCWrite=0, IF_ID_Write=0, PCSrc=10, jump_target=0x100.
  - Required: pc unchanged.
  - Required: after the stall releases with PCSrc=00, pc advances by 4, not to 0x100.
- Misaligned jr and wrap-around:
  - PCSrc=11, jr_target=0x103 → pc=0x100.
  - pc=0xFFFFFFFC, PCSrc=00 → pc=0x00000000 and IF_ID_PC4=0.
- Async reset mid-run: assert rst between edges while pc=0x20.
  - Required: pc=RESET_PC and Valid=0 immediately, with no clock edge needed.
  - Required: after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, picks the next fetch address and
// captures the fetched word into the IF/ID pipeline register.
module if_stage #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      PCWrite,
    input  logic                      IF_ID_Write,
    input  logic                      IF_Flush,
    input  logic [1:0]                PCSrc,
    input  logic [PC_WIDTH-1:0]       branch_target,
    input  logic [PC_WIDTH-1:0]       jump_target,
    input  logic [PC_WIDTH-1:0]       jr_target,
    output logic [PC_WIDTH-1:0]       imem_addr,
    input  logic [INSTR_WIDTH-1:0]    imem_data,
    output logic [PC_WIDTH-1:0]       pc,
    output logic [PC_WIDTH-1:0]       IF_ID_PC4,
    output logic [INSTR_WIDTH-1:0]    IF_ID_Instr,
    output logic                      IF_ID_Valid
);

    logic [PC_WIDTH-1:0]    pc_reg;
    logic [PC_WIDTH-1:0]    pc_plus4;
    logic [PC_WIDTH-1:0]    pc_sel;
    logic [PC_WIDTH-1:0]    next_pc;
    logic [PC_WIDTH-1:0]    if_id_pc4_reg;
    logic [INSTR_WIDTH-1:0] if_id_instr_reg;
    logic                   if_id_valid_reg;

    // Wraps silently at the top of the address space.
    assign pc_plus4 = pc_reg + PC_WIDTH'(4);

    always_comb begin
        pc_sel = pc_plus4;
        unique case (PCSrc)
            2'b00: pc_sel = pc_plus4;
            2'b01: pc_sel = branch_target;
            2'b10: pc_sel = jump_target;
            2'b11: pc_sel = jr_target;
        endcase
    end

    // Low two bits are dropped so a misaligned jr target still fetches a word.
    generate
        for (genvar gi = 0; gi < PC_WIDTH; gi++) begin : g_align
            if (gi < 2) begin : g_low
                assign next_pc[gi] = 1'b0;
            end else begin : g_high
                assign next_pc[gi] = pc_sel[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg <= RESET_PC;
        end else if (PCWrite) begin
            pc_reg <= next_pc;
        end
    end

    // Flush beats a held IF/ID so a squashed slot never survives a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_id_pc4_reg   <= '0;
            if_id_instr_reg <= '0;
            if_id_valid_reg <= 1'b0;
        end else if (IF_Flush) begin
            if_id_pc4_reg   <= pc_plus4;
            if_id_instr_reg <= '0;
            if_id_valid_reg <= 1'b0;
        end else if (IF_ID_Write) begin
            if_id_pc4_reg   <= pc_plus4;
            if_id_instr_reg <= imem_data;
            if_id_valid_reg <= 1'b1;
        end
    end

    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign IF_ID_PC4   = if_id_pc4_reg;
    assign IF_ID_Instr = if_id_instr_reg;
    assign IF_ID_Valid = if_id_valid_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed walk through the fetch scenarios, then random
// controls checked against a small behavioural model of the fetch stage.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write, if_id_write, if_flush;
    logic [1:0]  pc_src;
    logic [31:0] branch_target, jump_target, jr_target;
    logic [31:0] imem_addr, imem_data, pc, if_id_pc4, if_id_instr;
    logic        if_id_valid;

    int n_cmp = 0;
    int n_mis = 0;
    int n_txn = 0;

    // Reference state: what the fetch stage should hold right now.
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_valid;

    if_stage #(.PC_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .PCWrite(pc_write), .IF_ID_Write(if_id_write), .IF_Flush(if_flush),
        .PCSrc(pc_src), .branch_target(branch_target), .jump_target(jump_target),
        .jr_target(jr_target), .imem_addr(imem_addr), .imem_data(imem_data),
        .pc(pc), .IF_ID_PC4(if_id_pc4), .IF_ID_Instr(if_id_instr),
        .IF_ID_Valid(if_id_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return addr | 32'hA000_0000;
    endfunction

    assign imem_data = imem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic iw, input logic fl, input logic [1:0] src,
                         input logic [31:0] bt, input logic [31:0] jt, input logic [31:0] jrt);
        pc_write = pw; if_id_write = iw; if_flush = fl; pc_src = src;
        branch_target = bt; jump_target = jt; jr_target = jrt;
    endtask

    task automatic check_state(input string where);
        check({where, ".pc"},    pc,          m_pc);
        check({where, ".addr"},  imem_addr,   m_pc);
        check({where, ".pc4"},   if_id_pc4,   m_pc4);
        check({where, ".instr"}, if_id_instr, m_instr);
        check({where, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    endtask

    // One clock edge: advance the model from the applied controls, then compare.
    task automatic clock_check(input string where);
        logic [31:0] seq, tgt;
        seq = m_pc + 32'd4;
        case (pc_src)
            2'd0:    tgt = seq;
            2'd1:    tgt = branch_target;
            2'd2:    tgt = jump_target;
            default: tgt = jr_target;
        endcase
        tgt = tgt - (tgt % 4);
        if (if_flush) begin
            m_instr = 32'd0; m_pc4 = seq; m_valid = 1'b0;
        end else if (if_id_write) begin
            m_instr = imem_word(m_pc); m_pc4 = seq; m_valid = 1'b1;
        end
        if (pc_write) m_pc = tgt;
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d %s pw=%0b iw=%0b fl=%0b src=%0d pc=%h pc4=%h instr=%h v=%0b",
                 n_txn, where, pc_write, if_id_write, if_flush, pc_src, pc, if_id_pc4,
                 if_id_instr, if_id_valid);
        check_state(where);
    endtask

    // Called at posedge+1; pulses reset entirely between two edges.
    task automatic async_reset(input string where);
        #2 rst = 1'b1;
        #1;
        m_pc = RESET_PC; m_pc4 = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
        n_txn++;
        $display("txn %0d %s async reset pc=%h v=%0b", n_txn, where, pc, if_id_valid);
        check_state({where, ".rst"});
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        m_pc = RESET_PC; m_pc4 = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
        @(posedge clk);
        #1;
        check_state("reset");
        rst = 1'b0;

        // Sequential fetch, then a one-cycle load-use stall at pc=0x8.
        clock_check("seq0");
        check("seq0.instr_abs", if_id_instr, 32'hA000_0000);
        clock_check("seq1");
        check("seq1.pc_abs", pc, 32'h8);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        clock_check("stall");
        check("stall.instr_abs", if_id_instr, 32'hA000_0004);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        clock_check("resume");
        check("resume.instr_abs", if_id_instr, 32'hA000_0008);
        clock_check("seq3");

        // Taken branch at pc=0x10 with flush.
        drive(1'b1, 1'b1, 1'b1, 2'd1, 32'h40, 32'd0, 32'd0);
        clock_check("branch");
        check("branch.pc_abs", pc, 32'h40);
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        clock_check("after_br");
        check("after_br.instr_abs", if_id_instr, 32'hA000_0040);

        // Jump presented during a stall must be ignored.
        drive(1'b0, 1'b0, 1'b0, 2'd2, 32'd0, 32'h100, 32'd0);
        clock_check("jstall");
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'h100, 32'd0);
        clock_check("jrelease");
        check("jrelease.pc_abs", pc, 32'h48);

        // Misaligned jr, then wrap-around at the top of memory.
        drive(1'b1, 1'b1, 1'b1, 2'd3, 32'd0, 32'd0, 32'h103);
        clock_check("jr");
        check("jr.pc_abs", pc, 32'h100);
        drive(1'b1, 1'b1, 1'b1, 2'd3, 32'd0, 32'd0, 32'hFFFF_FFFC);
        clock_check("to_top");
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        clock_check("wrap");
        check("wrap.pc4_abs", if_id_pc4, 32'h0);

        // Async reset at pc=0x20, then restart from RESET_PC.
        drive(1'b1, 1'b1, 1'b1, 2'd2, 32'd0, 32'h20, 32'd0);
        clock_check("to_20");
        drive(1'b0, 1'b0, 1'b0, 2'd2, 32'd0, 32'h300, 32'd0);
        async_reset("mid");
        drive(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
        clock_check("restart");
        check("restart.instr_abs", if_id_instr, imem_word(RESET_PC));

        // Random controls, occasionally with a reset between edges.
        for (int i = 0; i < 200; i++) begin
            logic [1:0] mode;
            mode = 2'($urandom_range(0, 3));
            drive(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
                  (mode == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom,
                  $urandom, $urandom);
            if ($urandom_range(0, 24) == 0) async_reset("rnd");
            clock_check("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
